// File: rtl/phy_pkg.sv
// Shared PHY definitions: idle fill word, lane popcount and lane-slice offset helper.
package phy_pkg;

  localparam logic [7:0]  IDLE_WORD_DEF = 8'hBC;
  localparam int unsigned MAX_LANES     = 8;

  // Number of set bits in a lane-valid vector, zero-extended to MAX_LANES.
  function automatic logic [3:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < MAX_LANES; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  // Low bit of lane k inside a packed multi-lane bus.
  function automatic int unsigned lane_lo(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/rst_hold_stretch.sv
// Stretches the synchronous active-low reset: reset_out rises on the RST_HOLD-th
// consecutive edge at which reset is sampled high.
module rst_hold_stretch #(
  parameter int unsigned RST_HOLD = 2
) (
  input  logic clk_2f,
  input  logic reset,
  output logic reset_out
);

  logic [3:0] hold_cnt_r;
  logic [3:0] hold_next_s;
  logic       reset_out_r;

  // Next hold count: saturates at RST_HOLD, restarts whenever reset is low.
  always_comb begin
    hold_next_s = hold_cnt_r;
    if (!reset) begin
      hold_next_s = 4'd0;
    end else if (hold_cnt_r == 4'(RST_HOLD)) begin
      hold_next_s = hold_cnt_r;
    end else begin
      hold_next_s = hold_cnt_r + 4'd1;
    end
  end

  // Hold counter and registered stretched reset.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      hold_cnt_r  <= 4'd0;
      reset_out_r <= 1'b0;
    end else begin
      hold_cnt_r  <= hold_next_s;
      reset_out_r <= (hold_next_s == 4'(RST_HOLD));
    end
  end

  assign reset_out = reset_out_r;

endmodule

// File: rtl/lane_pipe_stage.sv
// Multi-lane PHY pipeline register: DEPTH stages with stall and flush, idle-word
// substitution on invalid lanes, stretched downstream reset and accepted-word counter.
module lane_pipe_stage
  import phy_pkg::*;
#(
  parameter int unsigned     LANES     = 4,
  parameter int unsigned     WIDTH     = 8,
  parameter int unsigned     DEPTH     = 2,
  parameter int unsigned     RST_HOLD  = 2,
  parameter logic [WIDTH-1:0] IDLE_WORD = IDLE_WORD_DEF,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic                   clk_2f,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] data_in,
  input  logic [LANES-1:0]       valid_in,
  input  logic                   enable,
  input  logic                   flush,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic [LANES-1:0]       valid_out,
  output logic                   reset_out,
  output logic [CNT_W-1:0]       word_count
);

  localparam logic [LANES*WIDTH-1:0] FLUSH_DATA = {LANES{IDLE_WORD}};

  logic [LANES*WIDTH-1:0] in_data_s;
  logic [MAX_LANES-1:0]   valid_ext_s;
  logic [CNT_W+3:0]       sum_s;
  logic [CNT_W-1:0]       cnt_next_s;
  logic [CNT_W-1:0]       word_count_r;

  rst_hold_stretch #(
    .RST_HOLD (RST_HOLD)
  ) u_rst_hold (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .reset_out (reset_out)
  );

  // Stage-0 data: invalid lanes carry the idle word instead of their input.
  always_comb begin
    in_data_s = FLUSH_DATA;
    for (int k = 0; k < LANES; k++) begin
      if (valid_in[k]) begin
        in_data_s[lane_lo(k, WIDTH) +: WIDTH] = data_in[lane_lo(k, WIDTH) +: WIDTH];
      end else begin
        in_data_s[lane_lo(k, WIDTH) +: WIDTH] = IDLE_WORD;
      end
    end
  end

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      logic [LANES*WIDTH-1:0] data_r;
      logic [LANES-1:0]       valid_r;
      logic [LANES*WIDTH-1:0] src_data_s;
      logic [LANES-1:0]       src_valid_s;

      if (i == 0) begin : g_head
        assign src_data_s  = in_data_s;
        assign src_valid_s = valid_in;
      end else begin : g_body
        assign src_data_s  = g_stage[i-1].data_r;
        assign src_valid_s = g_stage[i-1].valid_r;
      end

      // Stage register: reset clears to zero, flush empties to idle words.
      always_ff @(posedge clk_2f) begin
        if (!reset) begin
          data_r  <= {(LANES*WIDTH){1'b0}};
          valid_r <= {LANES{1'b0}};
        end else if (flush) begin
          data_r  <= FLUSH_DATA;
          valid_r <= {LANES{1'b0}};
        end else if (enable) begin
          data_r  <= src_data_s;
          valid_r <= src_valid_s;
        end else begin
          data_r  <= data_r;
          valid_r <= valid_r;
        end
      end
    end
  endgenerate

  assign data_out  = g_stage[DEPTH-1].data_r;
  assign valid_out = g_stage[DEPTH-1].valid_r;

  // Widened sum keeps the carry so saturation can be detected.
  always_comb begin
    valid_ext_s = {MAX_LANES{1'b0}};
    valid_ext_s[LANES-1:0] = valid_in;
    sum_s = {4'd0, word_count_r} + {{CNT_W{1'b0}}, popcount(valid_ext_s)};
    if (sum_s[CNT_W+3:CNT_W] != 4'd0) begin
      cnt_next_s = {CNT_W{1'b1}};
    end else begin
      cnt_next_s = sum_s[CNT_W-1:0];
    end
  end

  // Accepted-word counter: advances only on accepting cycles, survives flush.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      word_count_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      word_count_r <= word_count_r;
    end else if (enable) begin
      word_count_r <= cnt_next_s;
    end else begin
      word_count_r <= word_count_r;
    end
  end

  assign word_count = word_count_r;

endmodule

// File: tb/tb_lane_pipe_stage.sv
// Scoreboard bench for lane_pipe_stage: directed vectors push expected words,
// a negedge monitor pops and compares whenever a new valid word emerges.
module tb_lane_pipe_stage;

  logic        clk_2f;
  logic        reset;
  logic [31:0] data_in;
  logic [3:0]  valid_in;
  logic        enable;
  logic        flush;
  logic [31:0] data_out;
  logic [3:0]  valid_out;
  logic        reset_out;
  logic [15:0] word_count;
  logic [31:0] s_data_out;
  logic [3:0]  s_valid_out;
  logic        s_reset_out;
  logic [3:0]  s_word_count;

  lane_pipe_stage u_dut (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .enable     (enable),
    .flush      (flush),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .reset_out  (reset_out),
    .word_count (word_count)
  );

  lane_pipe_stage #(.CNT_W(4)) u_sat (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .enable     (enable),
    .flush      (flush),
    .data_out   (s_data_out),
    .valid_out  (s_valid_out),
    .reset_out  (s_reset_out),
    .word_count (s_word_count)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  // Hand-computed vectors: input data, lane valids, expected output, valid count.
  logic [31:0] vd [6] = '{32'h44332211, 32'hDDCCBBAA, 32'h87654321,
                          32'h01020304, 32'h55667788, 32'h0A0B0C0D};
  logic [3:0]  vv [6] = '{4'hF, 4'h5, 4'hA, 4'h1, 4'h8, 4'h6};
  logic [31:0] ve [6] = '{32'h44332211, 32'hBCCCBCAA, 32'h87BC43BC,
                          32'hBCBCBC04, 32'h55BCBCBC, 32'hBC0B0CBC};
  int          vp [6] = '{4, 2, 2, 1, 1, 2};

  logic [35:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_cnt = 0;
  int          exp_sat = 0;
  bit          adv = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic issue(input int idx);
    data_in  = vd[idx];
    valid_in = vv[idx];
    enable   = 1'b1;
    flush    = 1'b0;
    exp_q.push_back({ve[idx], vv[idx]});
    exp_cnt += vp[idx];
    tick();
    chk("word_count", 64'(word_count), 64'(exp_cnt));
  endtask

  task automatic idle_step();
    data_in  = 32'hFFFF_FFFF;
    valid_in = 4'h0;
    enable   = 1'b1;
    flush    = 1'b0;
    tick();
  endtask

  // Records whether the last edge shifted the pipeline.
  always @(posedge clk_2f) adv = reset && enable && !flush;

  // Monitor: each newly shifted valid output word must match the queue head.
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk_2f);
      if (adv && valid_out != 4'h0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(data_out), 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", 64'(data_out), 64'(e[35:4]));
          chk("sb_valid", 64'(valid_out), 64'(e[3:0]));
        end
      end
    end
  end

  initial begin
    logic [31:0] hold_d;
    logic [3:0]  hold_v;
    int          hold_c;

    reset = 1'b0; enable = 1'b0; flush = 1'b0;
    data_in = 32'hA5A5_A5A5; valid_in = 4'hF;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("rst_data", 64'(data_out), 64'h0);
      chk("rst_valid", 64'(valid_out), 64'h0);
      chk("rst_count", 64'(word_count), 64'h0);
      chk("rst_out_low", 64'(reset_out), 64'h0);
    end
    reset = 1'b1;
    tick();
    chk("rst_out_edge1", 64'(reset_out), 64'h0);
    tick();
    chk("rst_out_edge2", 64'(reset_out), 64'h1);

    // Full and partial lane words.
    issue(0);
    issue(1);
    idle_step();
    idle_step();

    // Stall: outputs and count frozen, stall-time inputs never queued.
    issue(2);
    issue(3);
    hold_d = data_out; hold_v = valid_out; hold_c = exp_cnt;
    chk("pre_stall_data", 64'(hold_d), 64'h87BC43BC);
    for (int n = 0; n < 3; n++) begin
      data_in = 32'h1111_1111 * (n + 1); valid_in = 4'hF; enable = 1'b0;
      tick();
      chk("stall_data", 64'(data_out), 64'(hold_d));
      chk("stall_valid", 64'(valid_out), 64'(hold_v));
      chk("stall_count", 64'(word_count), 64'(hold_c));
    end
    issue(4);
    issue(5);
    idle_step();
    idle_step();
    chk("drain_empty", 64'(exp_q.size()), 64'h0);

    // Flush with enable: pipeline emptied to idle words, count kept.
    issue(0);
    data_in = 32'h9999_9999; valid_in = 4'hF; enable = 1'b1; flush = 1'b1;
    tick();
    exp_q.delete();
    chk("flush_valid", 64'(valid_out), 64'h0);
    chk("flush_data", 64'(data_out), 64'hBCBCBCBC);
    chk("flush_count", 64'(word_count), 64'(exp_cnt));
    issue(2);
    chk("post_flush_empty", 64'(valid_out), 64'h0);
    chk("post_flush_idle", 64'(data_out), 64'hBCBCBCBC);
    idle_step();
    idle_step();

    // Mid-stream reset, then saturation of the narrow counter.
    issue(3);
    reset = 1'b0; data_in = 32'h7777_7777; valid_in = 4'hF; enable = 1'b1;
    tick();
    exp_q.delete();
    exp_cnt = 0;
    chk("mid_rst_data", 64'(data_out), 64'h0);
    chk("mid_rst_valid", 64'(valid_out), 64'h0);
    chk("mid_rst_out", 64'(reset_out), 64'h0);
    chk("mid_rst_count", 64'(word_count), 64'h0);
    chk("mid_rst_sat", 64'(s_word_count), 64'h0);
    reset = 1'b1;
    for (int n = 0; n < 5; n++) begin
      issue(0);
      exp_sat = (exp_sat + 4 > 15) ? 15 : exp_sat + 4;
      chk("sat_count", 64'(s_word_count), 64'(exp_sat));
      if (n == 0) chk("mid_rst_out_e1", 64'(reset_out), 64'h0);
      if (n == 1) chk("mid_rst_out_e2", 64'(reset_out), 64'h1);
    end
    chk("sat_final", 64'(s_word_count), 64'd15);
    idle_step();
    idle_step();
    idle_step();
    chk("final_empty", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
